// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer and instruction memory.
//   imem_addr  : word-aligned fetch address (current PC)
//   imem_req   : fetch request, asserted only while fetching
//   imem_data  : returned instruction word
//   imem_valid : imem_data is valid this cycle
// Modports: master = sequencer side, slave = memory side.
interface instr_sequencer_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        imem_valid;

  modport master (output imem_addr, output imem_req,
                  input  imem_data, input  imem_valid);
  modport slave  (input  imem_addr, input  imem_req,
                  output imem_data, output imem_valid);
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle front end and phase sequencer feeding the control-signal
// generator. Holds the PC, fetches through the imem bus, latches the
// instruction register, slices out its fields and drives the 4-bit estado
// phase code. The PC is updated at COMMIT from branch/alu_zero feedback.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   imem                fetch bus (master side)
//   branch, alu_zero    branch decision inputs, sampled only in COMMIT
//   imm                 sign-extended branch offset
//   instr               latched instruction register
//   tipo/funct3/funct7/rd/rs1/rs2  combinational field slices of instr
//   estado              phase code (registered state)
//   fault               sticky illegal-opcode / fetch-timeout flag
//   cycle_cnt, instret_cnt  performance counters (only with SEQ_PERF_CNT_EN)
//
// Optional feature macro: SEQ_PERF_CNT_EN.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MEM_WAIT     = 1,
  parameter int          IMEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.master  imem,
  input  logic               branch,
  input  logic               alu_zero,
  input  logic [31:0]        imm,
  output logic [31:0]        instr,
  output logic [2:0]         tipo,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [3:0]         estado,
  output logic               fault
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'b0000,
    DECODE = 4'b0001,
    EXEC   = 4'b0010,
    ALU    = 4'b0011,
    MEM    = 4'b0100,
    COMMIT = 4'b0101,
    HALT   = 4'b1110,
    WB     = 4'b1111
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [3:0]  wait_cnt;
  logic [31:0] tmo_cnt;

  assign tipo   = instr[6:4];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign estado         = state;
  assign imem.imem_addr = pc;
  assign imem.imem_req  = (state == FETCH);

  // Taken branch only when the control block says branch and the ALU compare
  // came out zero; low bits are cleared when the PC is written.
  assign pc_next = (branch && alu_zero) ? pc + imm : pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr    <= 32'h0000_0013;
      fault    <= 1'b0;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_valid) begin
            instr   <= imem.imem_data;
            tmo_cnt <= '0;
            state   <= DECODE;
          end else if (tmo_cnt == 32'(IMEM_TIMEOUT - 1)) begin
            // This is the IMEM_TIMEOUT-th consecutive cycle without data.
            fault <= 1'b1;
            state <= HALT;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        DECODE: begin
          case (instr[6:4])
            3'b000, 3'b001, 3'b011, 3'b110: state <= EXEC;
            default: begin
              fault <= 1'b1;
              state <= HALT;
            end
          endcase
        end
        EXEC: state <= ALU;
        ALU: begin
          if (instr[6:4] == 3'b000) begin
            wait_cnt <= 4'(MEM_WAIT - 1);
            state    <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else                  state    <= WB;
        end
        WB: state <= COMMIT;
        COMMIT: begin
          pc    <= pc_next & ~32'h3;
          state <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != HALT)   cycle_cnt   <= cycle_cnt + 32'd1;
      if (state == COMMIT) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b1;
  logic        branch = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] instr;
  logic [2:0]  tipo, funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [3:0]  estado;
  logic        fault;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  logic [31:0] mem [0:15];
  int compared = 0;
  int mismatched = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LD   = 32'h0000_0083;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] ILL  = 32'h0000_007F;

  instr_sequencer_if imem_bus();
  assign imem_bus.imem_data  = mem[imem_bus.imem_addr[5:2]];
  assign imem_bus.imem_valid = valid;

  instr_sequencer #(.RESET_PC(32'h0), .MEM_WAIT(3), .IMEM_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem_bus.master),
    .branch(branch), .alu_zero(alu_zero), .imm(imm),
    .instr(instr), .tipo(tipo), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .estado(estado), .fault(fault)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 16; i++) mem[i] = NOP;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fill_nops();
    rst_n = 1'b0;
    tick(1);
    compared++; if (estado !== 4'b0000) begin mismatched++; $display("FAIL reset_estado got=%b exp=0000", estado); end
    compared++; if (imem_bus.imem_addr !== 32'h0) begin mismatched++; $display("FAIL reset_pc got=%h exp=0", imem_bus.imem_addr); end
    compared++; if (instr !== NOP) begin mismatched++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    compared++; if (fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault got=%b exp=0", fault); end
    rst_n = 1'b1;
    compared++; if (imem_bus.imem_req !== 1'b1) begin mismatched++; $display("FAIL reset_req got=%b exp=1", imem_bus.imem_req); end
  endtask

  task automatic test_addi();
    logic [3:0] exp_seq [6] = '{4'b0001, 4'b0010, 4'b0011, 4'b1111, 4'b0101, 4'b0000};
    fill_nops();
    mem[0] = ADDI;
    valid = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1);
      compared++; if (estado !== exp_seq[i]) begin mismatched++; $display("FAIL addi_seq[%0d] got=%b exp=%b", i, estado, exp_seq[i]); end
      if (i == 0) begin
        compared++; if ({tipo, funct3, funct7, rd, rs1, rs2} !== {3'b001, 3'b000, 7'd0, 5'd1, 5'd0, 5'd5}) begin
          mismatched++; $display("FAIL addi_fields got=%b/%b/%b/%0d/%0d/%0d exp=001/000/0/1/0/5", tipo, funct3, funct7, rd, rs1, rs2);
        end
      end
    end
    compared++; if (imem_bus.imem_addr !== 32'h4) begin mismatched++; $display("FAIL addi_next_pc got=%h exp=4", imem_bus.imem_addr); end
  endtask

  task automatic test_load();
    logic [3:0] exp_seq [9] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0100, 4'b0100, 4'b1111, 4'b0101, 4'b0000};
    fill_nops();
    mem[0] = LD;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick(1);
      compared++; if (estado !== exp_seq[i]) begin mismatched++; $display("FAIL load_seq[%0d] got=%b exp=%b", i, estado, exp_seq[i]); end
    end
    compared++; if (imem_bus.imem_addr !== 32'h4) begin mismatched++; $display("FAIL load_next_pc got=%h exp=4", imem_bus.imem_addr); end
  endtask

  task automatic test_branch();
    fill_nops();
    mem[4] = BEQ;
    // taken
    branch = 1'b0; alu_zero = 1'b0; imm = 32'hFFFF_FFF8;
    do_reset();
    tick(24);
    compared++; if (imem_bus.imem_addr !== 32'd16) begin mismatched++; $display("FAIL br_pc16 got=%h exp=10", imem_bus.imem_addr); end
    branch = 1'b1; alu_zero = 1'b1;
    tick(6);
    compared++; if (imem_bus.imem_addr !== 32'd8) begin mismatched++; $display("FAIL br_taken got=%h exp=8", imem_bus.imem_addr); end
    // not taken
    branch = 1'b0; alu_zero = 1'b0;
    do_reset();
    tick(24);
    branch = 1'b1; alu_zero = 1'b0;
    tick(6);
    compared++; if (imem_bus.imem_addr !== 32'd20) begin mismatched++; $display("FAIL br_not_taken got=%h exp=14", imem_bus.imem_addr); end
    branch = 1'b0;
  endtask

  task automatic test_illegal();
    fill_nops();
    mem[1] = ILL;
    do_reset();
    tick(7);
    compared++; if (estado !== 4'b0001 || fault !== 1'b0) begin mismatched++; $display("FAIL ill_decode estado=%b fault=%b exp=0001/0", estado, fault); end
    tick(1);
    compared++; if (estado !== 4'b1110 || fault !== 1'b1) begin mismatched++; $display("FAIL ill_halt estado=%b fault=%b exp=1110/1", estado, fault); end
    compared++; if (imem_bus.imem_req !== 1'b0) begin mismatched++; $display("FAIL ill_req got=%b exp=0", imem_bus.imem_req); end
    tick(5);
    compared++; if (estado !== 4'b1110 || imem_bus.imem_addr !== 32'h4 || fault !== 1'b1) begin
      mismatched++; $display("FAIL ill_hold estado=%b pc=%h fault=%b exp=1110/4/1", estado, imem_bus.imem_addr, fault);
    end
    rst_n = 1'b0;
    tick(1);
    compared++; if (estado !== 4'b0000 || imem_bus.imem_addr !== 32'h0 || fault !== 1'b0) begin
      mismatched++; $display("FAIL ill_reset estado=%b pc=%h fault=%b exp=0000/0/0", estado, imem_bus.imem_addr, fault);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    fill_nops();
    mem[0] = ADDI;
    valid = 1'b0;
    do_reset();
    tick(254);
    compared++; if (estado !== 4'b0000 || fault !== 1'b0) begin mismatched++; $display("FAIL tmo_254 estado=%b fault=%b exp=0000/0", estado, fault); end
    tick(1);
    compared++; if (estado !== 4'b1110 || fault !== 1'b1) begin mismatched++; $display("FAIL tmo_255 estado=%b fault=%b exp=1110/1", estado, fault); end
    // data arrives on the 200th fetch cycle
    do_reset();
    tick(199);
    valid = 1'b1;
    tick(1);
    compared++; if (estado !== 4'b0001 || fault !== 1'b0) begin mismatched++; $display("FAIL tmo_late_valid estado=%b fault=%b exp=0001/0", estado, fault); end
    tick(5);
    valid = 1'b0;
    // timeout count restarts for the next fetch
    tick(100);
    compared++; if (estado !== 4'b0000 || fault !== 1'b0 || imem_bus.imem_addr !== 32'h4) begin
      mismatched++; $display("FAIL tmo_cleared estado=%b fault=%b pc=%h exp=0000/0/4", estado, fault, imem_bus.imem_addr);
    end
    valid = 1'b1;
  endtask

  task automatic test_reset_mid_mem();
    fill_nops();
    mem[1] = LD;
    do_reset();
    tick(10);
    compared++; if (estado !== 4'b0100) begin mismatched++; $display("FAIL mid_mem_setup got=%b exp=0100", estado); end
    rst_n = 1'b0;
    tick(1);
    compared++; if (estado !== 4'b0000 || imem_bus.imem_addr !== 32'h0 || fault !== 1'b0) begin
      mismatched++; $display("FAIL mid_mem_reset estado=%b pc=%h fault=%b exp=0000/0/0", estado, imem_bus.imem_addr, fault);
    end
    rst_n = 1'b1;
    tick(1);
    compared++; if (estado !== 4'b0001) begin mismatched++; $display("FAIL mid_mem_restart got=%b exp=0001", estado); end
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf();
    fill_nops();
    mem[0] = ADDI; mem[1] = ADDI; mem[2] = ADDI;
    do_reset();
    compared++; if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin mismatched++; $display("FAIL perf_reset cyc=%0d ret=%0d exp=0/0", cycle_cnt, instret_cnt); end
    tick(18);
    compared++; if (cycle_cnt !== 32'd18 || instret_cnt !== 32'd3) begin mismatched++; $display("FAIL perf_cnt cyc=%0d ret=%0d exp=18/3", cycle_cnt, instret_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
`ifdef SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
